// File: rtl/bb_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Packages: util_funcs, bb_cache_pkg                                   |
// | Generic width helpers and the shared FSM encodings and width         |
// | functions for the block-buffer cache scheduler.                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+

package util_funcs;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : util_funcs

package bb_cache_pkg;
  import util_funcs::*;

  typedef enum logic [0:0] {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } rd_state_e;

  // Write address width; never narrower than one bit.
  function automatic int aw_f(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Width able to hold a slot count 0..count inclusive.
  function automatic int cw_f(input int count);
    return (clog2(count + 1) < 1) ? 1 : clog2(count + 1);
  endfunction

  // Slot pointer width; never narrower than one bit.
  function automatic int pw_f(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage : bb_cache_pkg
`default_nettype wire

// File: rtl/bb_slot_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module: bb_slot_ring                                                 |
// | Ring bookkeeping for the cache slots: write/read pointers, number    |
// | of filled-but-unread slots and the stored word count per slot.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bb_slot_ring
  import bb_cache_pkg::*;
#(
  parameter  int COUNT = 5,
  parameter  int LW    = 9,
  localparam int PW    = pw_f(COUNT),
  localparam int CW    = cw_f(COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_close_i,
  input  logic [LW-1:0] wr_len_i,
  input  logic          rd_open_i,
  input  logic          rd_close_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] full_cnt_o,
  output logic [LW-1:0] rd_len_o
);

  localparam logic [PW-1:0] LAST_PTR = PW'(COUNT - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] full_cnt_q, full_cnt_d;
  logic [LW-1:0] len_q [COUNT];

  // Next pointers wrap modulo COUNT; full count nets out simultaneous open/close.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    full_cnt_d = full_cnt_q;
    if (wr_close_i) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_close_i) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({wr_close_i, rd_open_i})
      2'b10:   full_cnt_d = full_cnt_q + CW'(1);
      2'b01:   full_cnt_d = full_cnt_q - CW'(1);
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_cnt_q <= full_cnt_d;
    end
  end

  // Per-slot word count, captured when the producer closes the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COUNT; i++) begin
        len_q[i] <= '0;
      end
    end else if (wr_close_i) begin
      len_q[wr_ptr_q] <= wr_len_i;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign full_cnt_o = full_cnt_q;
  assign rd_len_o   = len_q[rd_ptr_q];

endmodule : bb_slot_ring
`default_nettype wire

// File: rtl/bb_cache_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module: bb_cache_scheduler                                           |
// | Hands out a ring of cache slots to one producer and one consumer.   |
// | Independent write and read FSMs; write address counter with sticky |
// | overflow detection.                                                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bb_cache_scheduler
  import bb_cache_pkg::*;
#(
  parameter  int BB_CACHE_COUNT = 5,
  parameter  int BB_CACHE_DEPTH = 170,
  localparam int AW             = aw_f(BB_CACHE_DEPTH),
  localparam int CW             = cw_f(BB_CACHE_COUNT),
  localparam int PW             = pw_f(BB_CACHE_COUNT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_req_in,
  output logic                      wr_grant_out,
  input  logic                      wr_valid_in,
  input  logic                      wr_done_in,
  output logic [BB_CACHE_COUNT-1:0] port_a_chip_sel_out,
  output logic [AW-1:0]             port_a_wrt_addr_out,
  output logic                      port_a_wrt_en_out,
  input  logic                      rd_req_in,
  output logic                      rd_grant_out,
  output logic [AW:0]               rd_len_out,
  input  logic                      rd_done_in,
  output logic [BB_CACHE_COUNT-1:0] port_b_chip_sel_out,
  output logic [CW-1:0]             full_cnt_out,
  output logic                      overflow_err_out
);

  localparam logic [BB_CACHE_COUNT-1:0] SEL_ONE   = BB_CACHE_COUNT'(1);
  localparam logic [AW:0]               DEPTH_W   = (AW + 1)'(BB_CACHE_DEPTH);
  localparam logic [CW:0]               COUNT_W   = (CW + 1)'(BB_CACHE_COUNT);

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [AW:0] wr_cnt_q, wr_cnt_d;
  logic        wr_grant_q, wr_grant_d;
  logic        rd_grant_q, rd_grant_d;
  logic        overflow_q, overflow_d;

  logic          wr_active;
  logic          rd_active;
  logic          wrt_en;
  logic          wr_close;
  logic [AW:0]   wr_len;
  logic          rd_open;
  logic          rd_close;
  logic [CW:0]   occupied;
  logic          room;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] full_cnt;
  logic [AW:0]   slot_len;

  assign wr_active = (wr_state_q == W_ACTIVE);
  assign rd_active = (rd_state_q == R_ACTIVE);

  // A word is dropped once the slot already holds DEPTH words.
  assign wrt_en = wr_valid_in && wr_active && (wr_cnt_q != DEPTH_W);

  // The slot held by the reader counts as occupied so the writer never lands on it.
  assign occupied = {1'b0, full_cnt} + (CW + 1)'(rd_active);
  assign room     = (occupied < COUNT_W);

  // Write FSM next-state: grant, word counting, overflow and slot close.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_grant_d = 1'b0;
    overflow_d = overflow_q;
    wr_close   = 1'b0;
    wr_len     = wr_cnt_q + (AW + 1)'(wrt_en);
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req_in && room) begin
          wr_state_d = W_ACTIVE;
          wr_grant_d = 1'b1;
          wr_cnt_d   = '0;
        end
      end
      W_ACTIVE: begin
        if (wrt_en) begin
          wr_cnt_d = wr_cnt_q + (AW + 1)'(1);
        end
        if (wr_valid_in && (wr_cnt_q == DEPTH_W)) begin
          overflow_d = 1'b1;
        end
        if (wr_done_in) begin
          wr_close   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read FSM next-state: grant consumes a filled slot, done releases it.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = 1'b0;
    rd_open    = 1'b0;
    rd_close   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req_in && (full_cnt != '0)) begin
          rd_state_d = R_ACTIVE;
          rd_grant_d = 1'b1;
          rd_open    = 1'b1;
        end
      end
      R_ACTIVE: begin
        if (rd_done_in) begin
          rd_state_d = R_IDLE;
          rd_close   = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State, grant pulse, word counter and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_cnt_q   <= '0;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      overflow_q <= overflow_d;
    end
  end

  bb_slot_ring #(
    .COUNT (BB_CACHE_COUNT),
    .LW    (AW + 1)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .wr_close_i (wr_close),
    .wr_len_i   (wr_len),
    .rd_open_i  (rd_open),
    .rd_close_i (rd_close),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .full_cnt_o (full_cnt),
    .rd_len_o   (slot_len)
  );

  assign wr_grant_out        = wr_grant_q;
  assign rd_grant_out        = rd_grant_q;
  assign port_a_chip_sel_out = wr_active ? (SEL_ONE << wr_ptr) : '0;
  assign port_b_chip_sel_out = rd_active ? (SEL_ONE << rd_ptr) : '0;
  assign port_a_wrt_addr_out = wr_cnt_q[AW-1:0];
  assign port_a_wrt_en_out   = wrt_en;
  assign rd_len_out          = rd_active ? slot_len : '0;
  assign full_cnt_out        = full_cnt;
  assign overflow_err_out    = overflow_q;

endmodule : bb_cache_scheduler
`default_nettype wire

// File: doc/bb_cache_scheduler.md
BB_CACHE_SCHEDULER -- requirements
Module: bb_cache_scheduler

Interface
REQ-001 SHALL have parameter BB_CACHE_COUNT, default 5, number of cache slots.
REQ-002 SHALL have parameter BB_CACHE_DEPTH, default 170, words per slot; AW = clog2(BB_CACHE_DEPTH), CW = clog2(BB_CACHE_COUNT+1).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_req_in  input  1  producer requests a free slot.
REQ-006 SHALL have port wr_grant_out  output  1  one-cycle pulse, slot allocated to producer.
REQ-007 SHALL have port wr_valid_in  input  1  producer word strobe.
REQ-008 SHALL have port wr_done_in  input  1  producer closes the current slot.
REQ-009 SHALL have port port_a_chip_sel_out  output  BB_CACHE_COUNT  one-hot write-slot select.
REQ-010 SHALL have port port_a_wrt_addr_out  output  AW  write address for the current word.
REQ-011 SHALL have port port_a_wrt_en_out  output  1  equals wr_valid_in gated by write-active and not-overflow.
REQ-012 SHALL have port rd_req_in  input  1  consumer requests a filled slot.
REQ-013 SHALL have port rd_grant_out  output  1  one-cycle pulse, filled slot allocated to consumer.
REQ-014 SHALL have port rd_len_out  output  AW+1  word count of the granted slot, valid from rd_grant_out until rd_done_in.
REQ-015 SHALL have port rd_done_in  input  1  consumer releases the current slot.
REQ-016 SHALL have port port_b_chip_sel_out  output  BB_CACHE_COUNT  one-hot read-slot select.
REQ-017 SHALL have port full_cnt_out  output  CW  number of filled, unread slots.
REQ-018 SHALL have port overflow_err_out  output  1  sticky write-past-depth error.

Function
REQ-019 Write FSM SHALL have states W_IDLE, W_ACTIVE; read FSM SHALL have states R_IDLE, R_ACTIVE; both run independently.
REQ-020 Slots SHALL be allocated in strict ring order: wr_ptr, rd_ptr in 0..BB_CACHE_COUNT-1, incremented modulo BB_CACHE_COUNT.
REQ-021 W_IDLE -> W_ACTIVE SHALL occur when wr_req_in=1 and full_cnt + (read FSM in R_ACTIVE) < BB_CACHE_COUNT; wr_grant_out pulses that same next cycle; port_a_chip_sel_out = onehot(wr_ptr) while W_ACTIVE, else 0.
REQ-022 In W_ACTIVE each wr_valid_in SHALL write at port_a_wrt_addr_out and then increment it; address resets to 0 on grant.
REQ-023 A wr_valid_in after BB_CACHE_DEPTH words SHALL be dropped (wrt_en=0) and set overflow_err_out until reset.
REQ-024 wr_done_in in W_ACTIVE SHALL store the word count (0..BB_CACHE_DEPTH) for slot wr_ptr, advance wr_ptr, increment full_cnt, return to W_IDLE; a wr_valid_in in the same cycle is written and counted.
REQ-025 R_IDLE -> R_ACTIVE SHALL occur when rd_req_in=1 and full_cnt>0; rd_grant_out pulses; port_b_chip_sel_out = onehot(rd_ptr) while R_ACTIVE, else 0; full_cnt decrements at grant.
REQ-026 rd_done_in in R_ACTIVE SHALL advance rd_ptr and return to R_IDLE.
REQ-027 Grant latency SHALL be exactly one cycle from qualifying request; no grant-to-grant bypass (slot closed by wr_done_in is grantable to the reader no earlier than the following cycle).
REQ-028 Simultaneous full_cnt increment and decrement SHALL leave full_cnt unchanged.
REQ-029 wr_done_in, wr_valid_in in W_IDLE and rd_done_in in R_IDLE SHALL be ignored.
REQ-030 port_a and port_b selects SHALL never be simultaneously nonzero in the same bit.

Reset
REQ-031 On reset all outputs SHALL be 0, FSMs in W_IDLE/R_IDLE, pointers 0, full_cnt 0, stored lengths 0, overflow cleared; reset mid-transfer discards all slot contents.

Structure
REQ-032 FSM state encodings and CW/AW helpers SHALL reside in shared package bb_cache_pkg; clog2 from util_funcs.
REQ-033 Pointer/full-count bookkeeping SHALL be one sub-module, bb_slot_ring; FSMs and address counter in the top.

Verification
REQ-034 After reset, wr_req 1 cycle -> wr_grant at cycle+1, chip_sel_a=5'b00001; 3 valids -> addr 0,1,2; done -> full_cnt=1.
REQ-035 rd_req with full_cnt=1 -> rd_grant next cycle, chip_sel_b=5'b00001, rd_len=3; rd_done -> R_IDLE.
REQ-036 Fill 5 slots without reads -> 6th wr_req held ungranted, full_cnt=5; one read grant+done -> write granted on slot 0 (wrap).
REQ-037 171 wr_valid in one slot -> 170 wrt_en pulses, overflow_err=1 sticky, rd_len=170.
REQ-038 wr_done and rd_grant same cycle with full_cnt=1 -> full_cnt stays 1; reset mid-W_ACTIVE -> all selects 0 next cycle.
